// File: rtl/phase_op_sequencer.sv
// Per-sample operator scheduler for the phase-increment / phase-accumulator datapath.
//
// On sample_clk_en the sequencer walks op_num through every operator slot, spending
// CYCLES_PER_OP clocks in each slot. It issues op_valid on the first cycle of each slot.
// It also produces a copy of op_valid/op_num (acc_we/op_num_p2) delayed by PIPE_DELAY
// clocks, so the accumulator write lines up with the phase-increment result.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   sample_clk_en  one-cycle strobe: start of a sample frame
//   clr_overrun    clears the sticky overrun flag
//   op_num         operator being issued (held outside RUN)
//   op_valid       issue strobe, first cycle of each slot
//   op_num_p2      op_num delayed PIPE_DELAY clocks
//   acc_we         op_valid delayed PIPE_DELAY clocks
//   busy           frame in progress (RUN or DRAIN)
//   frame_done     one-cycle pulse on the first IDLE cycle after DRAIN
//   overrun        sticky: sample_clk_en seen while busy
module phase_op_sequencer #(
  parameter int unsigned NUM_OPS       = 18,
  parameter int unsigned OP_NUM_WIDTH  = 5,
  parameter int unsigned CYCLES_PER_OP = 4,
  parameter int unsigned PIPE_DELAY    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_clk_en,
  input  logic                    clr_overrun,
  output logic [OP_NUM_WIDTH-1:0] op_num,
  output logic                    op_valid,
  output logic [OP_NUM_WIDTH-1:0] op_num_p2,
  output logic                    acc_we,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun
);

  // The slot counter is reused to time DRAIN, so size it for the larger of the two uses.
  localparam int unsigned CntMax = (CYCLES_PER_OP > PIPE_DELAY) ? CYCLES_PER_OP : PIPE_DELAY;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [OP_NUM_WIDTH-1:0] op_cnt_q, op_cnt_d;
  logic                    frame_done_q, frame_done_d;
  logic                    overrun_q, overrun_d;

  logic [PIPE_DELAY-1:0]   we_pipe_q;
  logic [OP_NUM_WIDTH-1:0] num_pipe_q [PIPE_DELAY];

  logic last_slot, last_op, drain_end;

  assign last_slot = (cnt_q == CntW'(CYCLES_PER_OP - 1));
  assign last_op   = (op_cnt_q == OP_NUM_WIDTH'(NUM_OPS - 1));
  assign drain_end = (cnt_q == CntW'(PIPE_DELAY - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_cnt_d     = op_cnt_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sample_clk_en) begin
          state_d  = StRun;
          cnt_d    = '0;
          op_cnt_d = '0;
        end
      end
      StRun: begin
        if (last_slot) begin
          cnt_d = '0;
          // op_cnt stays on the last operator so op_num holds it through DRAIN/IDLE.
          if (last_op) state_d = StDrain;
          else         op_cnt_d = op_cnt_q + OP_NUM_WIDTH'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        if (drain_end) begin
          state_d      = StIdle;
          cnt_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Set has priority over clear so a strobe coincident with clr_overrun is never lost.
  always_comb begin
    overrun_d = overrun_q;
    if (sample_clk_en && busy) overrun_d = 1'b1;
    else if (clr_overrun)      overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      op_cnt_q     <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_cnt_q     <= op_cnt_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Plain delay line matching the phase-increment pipeline; cleared on reset so no
  // pre-reset issue can produce a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_pipe_q <= '0;
      for (int i = 0; i < PIPE_DELAY; i++) num_pipe_q[i] <= '0;
    end else begin
      we_pipe_q[0]  <= op_valid;
      num_pipe_q[0] <= op_num;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        we_pipe_q[i]  <= we_pipe_q[i-1];
        num_pipe_q[i] <= num_pipe_q[i-1];
      end
    end
  end

  assign op_num     = op_cnt_q;
  assign op_valid   = (state_q == StRun) && (cnt_q == '0);
  assign op_num_p2  = num_pipe_q[PIPE_DELAY-1];
  assign acc_we     = we_pipe_q[PIPE_DELAY-1];
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_phase_op_sequencer.sv
// Scoreboard bench for phase_op_sequencer: stimulus tasks push expected events
// (issue, accumulator write, busy length, frame_done) and negedge monitors pop and
// compare whenever the DUT presents one. Instance u_dut0 uses default parameters,
// u_dut1 uses CYCLES_PER_OP=1.
module tb_phase_op_sequencer;

  typedef struct packed {
    int         cyc;
    logic [4:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en0 = 1'b0, clr0 = 1'b0, en1 = 1'b0, clr1 = 1'b0;
  logic [4:0] op_num0, op_num_p20, op_num1, op_num_p21;
  logic       op_valid0, acc_we0, busy0, done0, ovr0;
  logic       op_valid1, acc_we1, busy1, done1, ovr1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  ev_t exp_iss0[$], exp_acc0[$], exp_iss1[$];
  int  exp_done0[$], exp_busy0[$], exp_done1[$], exp_busy1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  phase_op_sequencer u_dut0 (
    .clk(clk), .reset(reset), .sample_clk_en(en0), .clr_overrun(clr0),
    .op_num(op_num0), .op_valid(op_valid0), .op_num_p2(op_num_p20), .acc_we(acc_we0),
    .busy(busy0), .frame_done(done0), .overrun(ovr0)
  );

  phase_op_sequencer #(.CYCLES_PER_OP(1)) u_dut1 (
    .clk(clk), .reset(reset), .sample_clk_en(en1), .clr_overrun(clr1),
    .op_num(op_num1), .op_valid(op_valid1), .op_num_p2(op_num_p21), .acc_we(acc_we1),
    .busy(busy1), .frame_done(done1), .overrun(ovr1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) next_cyc();
  endtask

  // Frame on u_dut0 strobed in the current cycle t.
  task automatic start0();
    int t;
    t = cyc;
    for (int k = 0; k < 18; k++) begin
      exp_iss0.push_back('{cyc: t + 1 + 4 * k, val: 5'(k)});
      exp_acc0.push_back('{cyc: t + 3 + 4 * k, val: 5'(k)});
    end
    exp_busy0.push_back(74);
    exp_done0.push_back(t + 75);
    en0 = 1'b1;
    next_cyc();
    en0 = 1'b0;
  endtask

  task automatic start1();
    int t;
    t = cyc;
    for (int k = 0; k < 18; k++) exp_iss1.push_back('{cyc: t + 1 + k, val: 5'(k)});
    exp_busy1.push_back(20);
    exp_done1.push_back(t + 21);
    en1 = 1'b1;
    next_cyc();
    en1 = 1'b0;
  endtask

  // Monitors for u_dut0
  bit bprev0 = 1'b0;
  int brun0 = 0;
  always @(negedge clk) begin
    ev_t e;
    if (op_valid0) begin
      checks++;
      if (exp_iss0.size() == 0) begin
        errors++;
        $display("FAIL issue0: unexpected op_valid at cycle %0d op_num %0d", cyc, op_num0);
      end else begin
        e = exp_iss0.pop_front();
        if (e.cyc != cyc || e.val != op_num0) begin
          errors++;
          $display("FAIL issue0: got cycle %0d op_num %0d expected cycle %0d op_num %0d",
                   cyc, op_num0, e.cyc, e.val);
        end
      end
    end
    if (acc_we0) begin
      checks++;
      if (exp_acc0.size() == 0) begin
        errors++;
        $display("FAIL accwe0: unexpected acc_we at cycle %0d op_num_p2 %0d", cyc, op_num_p20);
      end else begin
        e = exp_acc0.pop_front();
        if (e.cyc != cyc || e.val != op_num_p20) begin
          errors++;
          $display("FAIL accwe0: got cycle %0d op_num_p2 %0d expected cycle %0d op_num_p2 %0d",
                   cyc, op_num_p20, e.cyc, e.val);
        end
      end
    end
    if (done0) begin
      checks++;
      if (exp_done0.size() == 0) begin
        errors++;
        $display("FAIL done0: unexpected frame_done at cycle %0d", cyc);
      end else if (exp_done0[0] != cyc) begin
        errors++;
        $display("FAIL done0: got cycle %0d expected cycle %0d", cyc, exp_done0[0]);
        void'(exp_done0.pop_front());
      end else begin
        void'(exp_done0.pop_front());
      end
    end
    if (bprev0 && !busy0) begin
      checks++;
      if (exp_busy0.size() == 0) begin
        errors++;
        $display("FAIL busy0: unexpected busy run of %0d cycles", brun0);
      end else if (exp_busy0[0] != brun0) begin
        errors++;
        $display("FAIL busy0: got %0d busy cycles expected %0d", brun0, exp_busy0[0]);
        void'(exp_busy0.pop_front());
      end else begin
        void'(exp_busy0.pop_front());
      end
    end
    brun0 = busy0 ? (bprev0 ? brun0 + 1 : 1) : 0;
    bprev0 = busy0;
  end

  // Monitors for u_dut1
  bit bprev1 = 1'b0;
  int brun1 = 0;
  always @(negedge clk) begin
    ev_t e;
    if (op_valid1) begin
      checks++;
      if (exp_iss1.size() == 0) begin
        errors++;
        $display("FAIL issue1: unexpected op_valid at cycle %0d op_num %0d", cyc, op_num1);
      end else begin
        e = exp_iss1.pop_front();
        if (e.cyc != cyc || e.val != op_num1) begin
          errors++;
          $display("FAIL issue1: got cycle %0d op_num %0d expected cycle %0d op_num %0d",
                   cyc, op_num1, e.cyc, e.val);
        end
      end
    end
    if (done1) begin
      checks++;
      if (exp_done1.size() == 0 || exp_done1[0] != cyc) begin
        errors++;
        $display("FAIL done1: frame_done at cycle %0d not expected then", cyc);
      end
      if (exp_done1.size() != 0) void'(exp_done1.pop_front());
    end
    if (bprev1 && !busy1) begin
      checks++;
      if (exp_busy1.size() == 0 || exp_busy1[0] != brun1) begin
        errors++;
        $display("FAIL busy1: got %0d busy cycles, expected %0d", brun1,
                 (exp_busy1.size() != 0) ? exp_busy1[0] : 0);
      end
      if (exp_busy1.size() != 0) void'(exp_busy1.pop_front());
    end
    brun1 = busy1 ? (bprev1 ? brun1 + 1 : 1) : 0;
    bprev1 = busy1;
  end

  task automatic chk_zero0(input string tag);
    chk({tag, "_op_num"}, int'(op_num0), 0);
    chk({tag, "_op_valid"}, int'(op_valid0), 0);
    chk({tag, "_op_num_p2"}, int'(op_num_p20), 0);
    chk({tag, "_acc_we"}, int'(acc_we0), 0);
    chk({tag, "_busy"}, int'(busy0), 0);
    chk({tag, "_frame_done"}, int'(done0), 0);
    chk({tag, "_overrun"}, int'(ovr0), 0);
  endtask

  initial begin
    int r;
    // Reset state
    wait_cyc(3);
    reset = 1'b0;
    @(negedge clk);
    chk_zero0("reset");
    chk("reset_overrun1", int'(ovr1), 0);

    // Frame at 10: issues 11..79, writes 13..81, busy 11..84, done 85
    wait_cyc(10);
    start0();
    // Back-to-back frame on the frame_done cycle: accepted, not an overrun
    wait_cyc(85);
    chk("done_at_85", int'(done0), 1);
    start0();
    @(negedge clk);
    chk("b2b_overrun", int'(ovr0), 0);

    // Strobe mid-frame: frame unchanged, overrun sets; clear later
    wait_cyc(115);
    en0 = 1'b1;
    next_cyc();
    en0 = 1'b0;
    @(negedge clk);
    chk("overrun_set", int'(ovr0), 1);
    wait_cyc(170);
    chk("overrun_held", int'(ovr0), 1);
    clr0 = 1'b1;
    next_cyc();
    clr0 = 1'b0;
    @(negedge clk);
    chk("overrun_clr", int'(ovr0), 0);

    // Reset mid-frame at 200: everything after is dropped, busy ran 181..200
    wait_cyc(180);
    start0();
    wait_cyc(200);
    r = cyc;
    while (exp_iss0.size() != 0 && exp_iss0[$].cyc > r) void'(exp_iss0.pop_back());
    while (exp_acc0.size() != 0 && exp_acc0[$].cyc > r) void'(exp_acc0.pop_back());
    while (exp_done0.size() != 0 && exp_done0[$] > r) void'(exp_done0.pop_back());
    if (exp_busy0.size() != 0) void'(exp_busy0.pop_back());
    exp_busy0.push_back(20);
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    chk_zero0("abort");

    // Fresh frame after the abort
    wait_cyc(210);
    start0();

    // CYCLES_PER_OP=1: issues 301..318, busy 20, done 321
    wait_cyc(300);
    start1();
    wait_cyc(305);
    en1 = 1'b1;
    clr1 = 1'b1;
    next_cyc();
    en1 = 1'b0;
    clr1 = 1'b0;
    @(negedge clk);
    chk("set_wins_overrun1", int'(ovr1), 1);

    wait_cyc(340);
    chk("left_issue0", exp_iss0.size(), 0);
    chk("left_accwe0", exp_acc0.size(), 0);
    chk("left_done0", exp_done0.size(), 0);
    chk("left_busy0", exp_busy0.size(), 0);
    chk("left_issue1", exp_iss1.size(), 0);
    chk("left_done1", exp_done1.size(), 0);
    chk("left_busy1", exp_busy1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
